// File: rtl/bb_decode.sv
// Blackbone single-master to multi-slave address decoder.
// Steers each access to the lowest-index matching window, returns read data one cycle later, and logs unmapped accesses.
module bb_decode #(
    parameter int                             SLAVES     = 2,
    parameter int                             DATA_WIDTH = 32,
    parameter int                             ADDR_WIDTH = 32,
    parameter logic [SLAVES*ADDR_WIDTH-1:0]   S_BASE     = '0,
    parameter logic [SLAVES*ADDR_WIDTH-1:0]   S_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0]          ERR_DATA   = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [ADDR_WIDTH-1:0]                m_addr_i,
    input  logic [DATA_WIDTH-1:0]                m_din_i,
    input  logic                                 m_en_i,
    input  logic                                 m_we_i,
    output logic [DATA_WIDTH-1:0]                m_dout_o,
    output logic [SLAVES-1:0][ADDR_WIDTH-1:0]    s_addr_o,
    output logic [SLAVES-1:0][DATA_WIDTH-1:0]    s_din_o,
    output logic [SLAVES-1:0]                    s_en_o,
    output logic [SLAVES-1:0]                    s_we_o,
    input  logic [SLAVES-1:0][DATA_WIDTH-1:0]    s_dout_i,
    output logic                                 err_o,
    output logic [ADDR_WIDTH-1:0]                err_addr_o,
    output logic [15:0]                          err_cnt_o,
    input  logic                                 err_clr_i
);

    localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIT,
        ST_MISS
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    err_q, err_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   eaddr_q, eaddr_d;
    logic                    vld_q, vld_d;

    logic [SLAVES-1:0]       match;
    logic [SLAVES-1:0]       sel;
    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;
    logic                    miss;

    genvar gi;
    generate
        for (gi = 0; gi < SLAVES; gi++) begin : g_slave
            assign match[gi]    = ((m_addr_i & S_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH])
                                   == S_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH]);
            assign s_addr_o[gi] = m_addr_i;
            assign s_din_o[gi]  = m_din_i;
            assign s_en_o[gi]   = m_en_i & sel[gi];
            assign s_we_o[gi]   = m_en_i & m_we_i & sel[gi];
        end
    endgenerate

    // Overlapping windows resolve to the lowest index, keeping sel one-hot.
    always_comb begin
        sel     = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (match[i] && !hit) begin
                hit     = 1'b1;
                sel[i]  = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign miss = m_en_i & ~hit;

    always_comb begin
        state_d = ST_IDLE;
        idx_d   = idx_q;
        if (m_en_i && !m_we_i) begin
            if (hit) begin
                state_d = ST_HIT;
                idx_d   = hit_idx;
            end else begin
                state_d = ST_MISS;
            end
        end
    end

    always_comb begin
        m_dout_o = '0;
        case (state_q)
            ST_HIT:  m_dout_o = s_dout_i[idx_q];
            ST_MISS: m_dout_o = ERR_DATA;
            default: m_dout_o = '0;
        endcase
    end

    // Clear is applied first so a simultaneous miss is counted and captured on top of it.
    always_comb begin
        err_d   = miss;
        cnt_d   = cnt_q;
        eaddr_d = eaddr_q;
        vld_d   = vld_q;
        if (err_clr_i) begin
            cnt_d   = '0;
            eaddr_d = '0;
            vld_d   = 1'b0;
        end
        if (miss) begin
            if (cnt_d != 16'hFFFF) begin
                cnt_d = cnt_d + 16'd1;
            end
            if (!vld_d) begin
                eaddr_d = m_addr_i;
                vld_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            eaddr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            eaddr_q <= eaddr_d;
            vld_q   <= vld_d;
        end
    end

    assign err_o      = err_q;
    assign err_cnt_o  = cnt_q;
    assign err_addr_o = eaddr_q;

endmodule

// File: tb/tb_bb_decode.sv
// Self-checking bench for bb_decode: directed vector table, reset-mid-read and saturation sequences,
// and randomized traffic checked against an address-region reference model.
module tb_bb_decode;

    localparam logic [63:0] BASES = {32'h0001_0000, 32'h0000_0000};
    localparam logic [63:0] MASKS = {32'hFFFF_0000, 32'hFFFF_0000};
    localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

    logic              clk;
    logic              rst_ni;
    logic [31:0]       m_addr;
    logic [31:0]       m_din;
    logic              m_en;
    logic              m_we;
    logic [31:0]       m_dout;
    logic [1:0][31:0]  s_addr;
    logic [1:0][31:0]  s_din;
    logic [1:0]        s_en;
    logic [1:0]        s_we;
    logic [1:0][31:0]  s_dout;
    logic              err;
    logic [31:0]       err_addr;
    logic [15:0]       err_cnt;
    logic              err_clr;

    int n_tests = 0;
    int n_fail  = 0;
    logic fixed_data = 1'b1;

    bb_decode #(
        .SLAVES(2), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .S_BASE(BASES), .S_MASK(MASKS), .ERR_DATA(ERRD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_addr_i(m_addr), .m_din_i(m_din), .m_en_i(m_en), .m_we_i(m_we),
        .m_dout_o(m_dout),
        .s_addr_o(s_addr), .s_din_o(s_din), .s_en_o(s_en), .s_we_o(s_we),
        .s_dout_i(s_dout),
        .err_o(err), .err_addr_o(err_addr), .err_cnt_o(err_cnt), .err_clr_i(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slave_val(input int k, input logic [31:0] a);
        return {(k == 1) ? 16'hB00B : 16'hA00A, a[15:0]};
    endfunction

    // Slave memory models: data appears the cycle after a read enable.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (s_en[k] && !s_we[k]) begin
                if (fixed_data) s_dout[k] <= (k == 1) ? 32'hBBBB_0000 : 32'hAAAA_0000;
                else            s_dout[k] <= slave_val(k, s_addr[k]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic we, input logic clr,
                         input logic [31:0] addr, input logic [31:0] din);
        @(negedge clk);
        m_en = en; m_we = we; err_clr = clr; m_addr = addr; m_din = din;
        #1;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        en, we, clr;
        logic [31:0] addr, din;
        logic [1:0]  exp_en, exp_we;
        logic [31:0] exp_dout;
        logic        exp_err;
        logic [15:0] exp_cnt;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t tbl[12];

    // Reference model state
    int          ref_cnt;
    logic        ref_vld;
    logic [31:0] ref_eaddr;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0001_0004, 32'h1234_5678, 2'b10, 2'b10, 32'h0,         1'b0, 16'd0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         2'b01, 2'b00, 32'hAAAA_0000, 1'b0, 16'd0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0001_0010, 32'h0,         2'b10, 2'b00, 32'hBBBB_0000, 1'b0, 16'd0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         2'b01, 2'b00, 32'hAAAA_0000, 1'b0, 16'd0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0002_0000, 32'h0,         2'b00, 2'b00, ERRD,          1'b1, 16'd1, 32'h0002_0000};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0003_0000, 32'h0,         2'b00, 2'b00, ERRD,          1'b1, 16'd2, 32'h0002_0000};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h0004_0000, 32'h0,         2'b00, 2'b00, ERRD,          1'b1, 16'd1, 32'h0004_0000};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         2'b00, 2'b00, 32'h0,         1'b0, 16'd1, 32'h0004_0000};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         2'b00, 2'b00, 32'h0,         1'b0, 16'd0, 32'h0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0005_0000, 32'hCAFE_0001, 2'b00, 2'b00, 32'h0,         1'b1, 16'd1, 32'h0005_0000};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0000_FFFC, 32'h0,         2'b01, 2'b00, 32'hAAAA_0000, 1'b0, 16'd1, 32'h0005_0000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0001_FFFF, 32'h0,         2'b10, 2'b00, 32'hBBBB_0000, 1'b0, 16'd1, 32'h0005_0000};

        rst_ni = 1'b0; m_en = 1'b0; m_we = 1'b0; err_clr = 1'b0; m_addr = '0; m_din = '0;
        s_dout = '0;
        #2;
        check("reset_dout", m_dout, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        check("reset_cnt", {16'h0, err_cnt}, 32'h0);
        check("reset_eaddr", err_addr, 32'h0);
        check("reset_sen", {30'h0, s_en}, 32'h0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Directed vector table
        fixed_data = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].en, tbl[i].we, tbl[i].clr, tbl[i].addr, tbl[i].din);
            check($sformatf("v%0d_s_en", i), {30'h0, s_en}, {30'h0, tbl[i].exp_en});
            check($sformatf("v%0d_s_we", i), {30'h0, s_we}, {30'h0, tbl[i].exp_we});
            check($sformatf("v%0d_s_addr1", i), s_addr[1], tbl[i].addr);
            check($sformatf("v%0d_s_din0", i), s_din[0], tbl[i].din);
            settle();
            check($sformatf("v%0d_dout", i), m_dout, tbl[i].exp_dout);
            check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
            check($sformatf("v%0d_cnt", i), {16'h0, err_cnt}, {16'h0, tbl[i].exp_cnt});
            check($sformatf("v%0d_eaddr", i), err_addr, tbl[i].exp_eaddr);
            $display("[TB] vec %0d en=%0b we=%0b clr=%0b addr=%h dout=%h cnt=%0d",
                     i, tbl[i].en, tbl[i].we, tbl[i].clr, tbl[i].addr, m_dout, err_cnt);
        end

        // Randomized traffic against the region model
        ref_cnt = 1; ref_vld = 1'b1; ref_eaddr = 32'h0005_0000;
        fixed_data = 1'b0;
        for (int t = 0; t < 500; t++) begin
            logic        en, we, clr;
            logic [31:0] addr, din;
            logic [15:0] hi;
            int          k;
            logic [1:0]  e_en, e_we;
            logic [31:0] e_dout;
            logic        e_err;
            en  = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 9) < 3);
            clr = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       hi = 16'h0000;
                1:       hi = 16'h0001;
                2:       hi = 16'($urandom_range(0, 16'hFFFF));
                default: hi = 16'h0000;
            endcase
            addr = {hi, 16'($urandom)};
            din  = $urandom;
            k = (hi == 16'h0000) ? 0 : (hi == 16'h0001) ? 1 : -1;
            e_en   = (en && k >= 0) ? 2'(1 << k) : 2'b00;
            e_we   = we ? e_en : 2'b00;
            e_dout = (en && !we) ? ((k >= 0) ? slave_val(k, addr) : ERRD) : 32'h0;
            e_err  = en && (k < 0);
            if (clr) begin ref_cnt = 0; ref_vld = 1'b0; ref_eaddr = '0; end
            if (e_err) begin
                if (ref_cnt < 65535) ref_cnt++;
                if (!ref_vld) begin ref_vld = 1'b1; ref_eaddr = addr; end
            end
            drive(en, we, clr, addr, din);
            check("rnd_s_en", {30'h0, s_en}, {30'h0, e_en});
            check("rnd_s_we", {30'h0, s_we}, {30'h0, e_we});
            settle();
            check("rnd_dout", m_dout, e_dout);
            check("rnd_err", {31'h0, err}, {31'h0, e_err});
            check("rnd_cnt", {16'h0, err_cnt}, 32'(ref_cnt));
            check("rnd_eaddr", err_addr, ref_eaddr);
            $display("[TB] rnd %0d en=%0b we=%0b clr=%0b addr=%h dout=%h cnt=%0d",
                     t, en, we, clr, addr, m_dout, err_cnt);
        end

        // Reset while a slave1 read is in flight
        fixed_data = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0009_0000, 32'h0);
        settle();
        drive(1'b1, 1'b0, 1'b0, 32'h0001_0008, 32'h0);
        settle();
        check("pre_rst_dout", m_dout, 32'hBBBB_0000);
        m_en = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        check("rst_dout", m_dout, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_cnt", {16'h0, err_cnt}, 32'h0);
        check("rst_eaddr", err_addr, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
        settle();
        check("post_rst_dout", m_dout, 32'hAAAA_0000);
        $display("[TB] reset-mid-read dout=%h", m_dout);

        // Counter saturation
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            m_en = 1'b1; m_we = i[0]; err_clr = 1'b0; m_addr = 32'h8000_0000 | i;
            @(posedge clk);
            #1;
            if (i == 65533) check("sat_cnt_fffe", {16'h0, err_cnt}, 32'h0000_FFFE);
        end
        check("sat_cnt_ffff", {16'h0, err_cnt}, 32'h0000_FFFF);
        repeat (4) begin
            drive(1'b1, 1'b0, 1'b0, 32'h9000_0000, 32'h0);
            settle();
        end
        check("sat_hold", {16'h0, err_cnt}, 32'h0000_FFFF);
        check("sat_eaddr", err_addr, 32'h8000_0000);
        check("sat_err", {31'h0, err}, 32'h1);
        $display("[TB] saturation cnt=%h eaddr=%h", err_cnt, err_addr);

        m_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
